// File: rtl/i2c_pkg.sv
// Shared I2C definitions: controller state encoding, R/W bit encoding and the
// default target address used by the controller and the peripheral.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR_W,
    ST_REG,
    ST_DATA_W,
    ST_RESTART,
    ST_ADDR_R,
    ST_DATA_R,
    ST_STOP
  } ctrl_state_e;

  // Same encoding as the peripheral's action enum so both ends agree on bit 0.
  typedef enum logic {
    I2C_WRITE = 1'b0,
    I2C_READ  = 1'b1
  } rw_e;

  localparam logic [6:0] DEFAULT_TGT_ADDR = 7'b0101010;

  function automatic logic [7:0] addr_byte(input logic [6:0] dev, input rw_e rw);
    return {dev, rw};
  endfunction

endpackage

// File: rtl/i2c_if.sv
// Control-side handshake between FPGA logic (master) and the I2C controller
// (slave): transaction request, read data and completion status.
interface i2c_if;

  logic       start;
  logic       rw;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       nack;

  modport master (
    output start, rw, dev_addr, reg_addr, wdata,
    input  rdata, busy, done, nack
  );

  modport slave (
    input  start, rw, dev_addr, reg_addr, wdata,
    output rdata, busy, done, nack
  );

endinterface

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period timebase: one-cycle tick every CLK_DIV clocks while
// enabled; the count freezes while a target stretches SCL.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic hold,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    tick  = en && !hold && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else if (!hold) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_controller.sv
// Single-transaction I2C controller: one register write or one single-byte
// register read per start pulse, on open-drain SCL/SDA with clock stretching.
module i2c_controller
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic  clk,
  input  logic  rst_n,
  i2c_if.slave  ctrl,
  inout  wire   scl,
  inout  wire   sda
);

  ctrl_state_e state_q, state_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  rw_e         rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        nack_q, nack_d;
  logic        ack_err_q, ack_err_d;
  logic        scl_low_q, scl_low_d;
  logic        sda_low_q, sda_low_d;

  logic tick, hold, scl_in, sda_in;

  assign scl    = scl_low_q ? 1'b0 : 1'bz;
  assign sda    = sda_low_q ? 1'b0 : 1'bz;
  assign scl_in = scl;
  assign sda_in = sda;

  // Released SCL still reading low means a target is stretching the clock.
  assign hold = !scl_low_q && !scl_in;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (busy_q),
    .hold (hold),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    nack_d    = nack_q;
    ack_err_d = ack_err_q;

    if (state_q == ST_IDLE) begin
      if (ctrl.start) begin
        state_d   = ST_START;
        rw_d      = rw_e'(ctrl.rw);
        dev_d     = ctrl.dev_addr;
        reg_d     = ctrl.reg_addr;
        wdata_d   = ctrl.wdata;
        busy_d    = 1'b1;
        nack_d    = 1'b0;
        ack_err_d = 1'b0;
        qtr_d     = 2'd0;
        bit_d     = 4'd0;
      end
    end else if (tick) begin
      qtr_d = qtr_q + 2'd1;
      if (qtr_q == 2'd3) begin
        case (state_q)
          ST_START: begin
            state_d = ST_ADDR_W;
            shift_d = addr_byte(dev_q, I2C_WRITE);
          end
          ST_RESTART: begin
            state_d = ST_ADDR_R;
            shift_d = addr_byte(dev_q, I2C_READ);
          end
          ST_STOP: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            nack_d  = ack_err_q;
          end
          default: begin
            if (bit_q != 4'd8) begin
              // One shifter serves both directions: TX bits fall out of the
              // top while the sampled SDA enters at the bottom.
              shift_d = {shift_q[6:0], sda_in};
              bit_d   = bit_q + 4'd1;
              if (state_q == ST_DATA_R && bit_q == 4'd7) begin
                rdata_d = {shift_q[6:0], sda_in};
              end
            end else begin
              bit_d = 4'd0;
              if (state_q != ST_DATA_R && sda_in) begin
                ack_err_d = 1'b1;
                state_d   = ST_STOP;
              end else begin
                case (state_q)
                  ST_ADDR_W: begin
                    state_d = ST_REG;
                    shift_d = reg_q;
                  end
                  ST_REG: begin
                    if (rw_q == I2C_READ) begin
                      state_d = ST_RESTART;
                    end else begin
                      state_d = ST_DATA_W;
                      shift_d = wdata_q;
                    end
                  end
                  ST_ADDR_R: begin
                    state_d = ST_DATA_R;
                    shift_d = 8'hFF;
                  end
                  default: state_d = ST_STOP;
                endcase
              end
            end
          end
        endcase
      end
    end

    // Line levels for the quarter being entered, registered so pins only move on ticks.
    scl_low_d = 1'b0;
    sda_low_d = 1'b0;
    case (state_d)
      ST_IDLE: ;
      ST_START: begin
        scl_low_d = qtr_d[1];
        sda_low_d = (qtr_d != 2'd0);
      end
      ST_RESTART: begin
        scl_low_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
        sda_low_d = qtr_d[1];
      end
      ST_STOP: begin
        scl_low_d = !qtr_d[1];
        sda_low_d = (qtr_d != 2'd3);
      end
      default: begin
        scl_low_d = !qtr_d[1];
        sda_low_d = (bit_d != 4'd8) && !shift_d[7];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      qtr_q     <= 2'd0;
      bit_q     <= 4'd0;
      shift_q   <= 8'h00;
      rw_q      <= I2C_WRITE;
      dev_q     <= DEFAULT_TGT_ADDR;
      reg_q     <= 8'h00;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
      ack_err_q <= 1'b0;
      scl_low_q <= 1'b0;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
      ack_err_q <= ack_err_d;
      scl_low_q <= scl_low_d;
      sda_low_q <= sda_low_d;
    end
  end

  assign ctrl.rdata = rdata_q;
  assign ctrl.busy  = busy_q;
  assign ctrl.done  = done_q;
  assign ctrl.nack  = nack_q;

endmodule
